// File: rtl/cpu7_pkg.sv
// cpu7_pkg: shared constants and types for the CPU7 code-fetch path.
//   - WT_* code-word type codes, WT_MASK / MASK14 field masks
//   - kind_e result kind reported on out_kind
//   - literal chunk width and default literal width
package cpu7_pkg;

    localparam int unsigned CHUNK_W         = 14;
    localparam int unsigned MAX_CHUNKS_DFLT = 4;
    localparam int unsigned LIT_W           = CHUNK_W * MAX_CHUNKS_DFLT;

    localparam logic [1:0]  WT_DNL = 2'b00;
    localparam logic [1:0]  WT_IGN = 2'b01;
    localparam logic [1:0]  WT_CPU = 2'b10;
    localparam logic [1:0]  WT_RSV = 2'b11;

    localparam logic [15:0] WT_MASK = 16'hC000;
    localparam logic [13:0] MASK14  = 14'h3FFF;

    typedef enum logic [1:0] {
        K_PUSH  = 2'd0,
        K_INSTR = 2'd1,
        K_SKIP  = 2'd2
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_DECODE = 2'd2,
        S_EMIT   = 2'd3
    } state_e;

    // Type field of a 16-bit code word.
    function automatic logic [1:0] word_type(input logic [15:0] w);
        logic [15:0] t;
        t = w & WT_MASK;
        return t[15:14];
    endfunction

    // Payload field of a 16-bit code word.
    function automatic logic [13:0] word_payload(input logic [15:0] w);
        return w[13:0] & MASK14;
    endfunction

endpackage

// File: rtl/code_fetch_lit_accum.sv
// lit_accum: little-endian literal chunk accumulator.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : empty the accumulator, count and overlong flag
//   load, payload : append one 14-bit chunk (dropped once MAX_CHUNKS are held)
//   set_ovl       : force the sticky overlong flag
//   value_c       : extended literal including this cycle's chunk (combinational)
//   count         : chunks stored, saturating at MAX_CHUNKS
//   overlong      : sticky overlong flag
// Build option: CODE_FETCH_SIGN_EXT_EN selects sign extension from bit 13 of
// the highest stored chunk; otherwise the literal is zero-extended.
module lit_accum
    import cpu7_pkg::*;
#(
    parameter int unsigned MAX_CHUNKS = MAX_CHUNKS_DFLT,
    localparam int unsigned VAL_W     = CHUNK_W * MAX_CHUNKS,
    localparam int unsigned CNT_W     = $clog2(MAX_CHUNKS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               set_ovl,
    input  logic [13:0]        payload,
    output logic [VAL_W-1:0]   value_c,
    output logic [CNT_W-1:0]   count,
    output logic               overlong
);

    logic [VAL_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovl_q, ovl_d;

    // Chunk insert at offset 14*count; a chunk with no room only flags overlong.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovl_d = ovl_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovl_d = 1'b0;
        end else begin
            if (load) begin
                if (cnt_q < CNT_W'(MAX_CHUNKS)) begin
                    acc_d = acc_q | (VAL_W'(payload) << (CHUNK_W * 32'(cnt_q)));
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    ovl_d = 1'b1;
                end
            end
            if (set_ovl) begin
                ovl_d = 1'b1;
            end
        end
    end

`ifdef CODE_FETCH_SIGN_EXT_EN
    logic [VAL_W-1:0] mask;
    logic             sign;

    // Ascending loop: the last stored chunk's bit 13 is the sign.
    always_comb begin
        mask = '0;
        sign = 1'b0;
        for (int i = 0; i < int'(MAX_CHUNKS); i++) begin
            if (32'(i) < 32'(cnt_d)) begin
                mask[i*CHUNK_W +: CHUNK_W] = '1;
                sign = acc_d[i*CHUNK_W + CHUNK_W - 1];
            end
        end
        value_c = sign ? (acc_d | ~mask) : acc_d;
    end
`else
    always_comb begin
        value_c = acc_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovl_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovl_q <= ovl_d;
        end
    end

    assign count    = cnt_q;
    assign overlong = ovl_q;

endmodule

// File: rtl/code_fetch.sv
// code_fetch: walks code words from the program BRAM, assembles literals or
// extracts a CPU instruction, and hands the result over valid/ready.
//   clk, rst                 : clock, synchronous active-high reset
//   start, start_pcp, exec   : fetch request (sampled only when idle)
//   mem_addr, mem_data       : BRAM read port (one-cycle registered read)
//   out_valid, out_ready     : result handshake
//   out_kind/instr/value/pcp : result payload, pcp is just past the last word
//   busy                     : fetch in progress
//   err_overlong, err_rsv    : sticky errors, cleared on an accepted start
// Build option: CODE_FETCH_SIGN_EXT_EN (see lit_accum).
module code_fetch
    import cpu7_pkg::*;
#(
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned MAX_CHUNKS = MAX_CHUNKS_DFLT,
    localparam int unsigned VAL_W     = CHUNK_W * MAX_CHUNKS,
    localparam int unsigned CNT_W     = $clog2(MAX_CHUNKS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pcp,
    input  logic               exec,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [15:0]        mem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_kind,
    output logic [13:0]        out_instr,
    output logic [VAL_W-1:0]   out_value,
    output logic [ADDR_W-1:0]  out_pcp,
    output logic               busy,
    output logic               err_overlong,
    output logic               err_rsv
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                exec_q, exec_d;
    logic                out_valid_q, out_valid_d;
    kind_e               kind_q, kind_d;
    logic [13:0]         instr_q, instr_d;
    logic [VAL_W-1:0]    value_q, value_d;
    logic [ADDR_W-1:0]   pcp_q, pcp_d;
    logic                busy_q, busy_d;
    logic                err_rsv_q, err_rsv_d;

    logic                lit_clear, lit_load, lit_set_ovl;
    logic [VAL_W-1:0]    lit_value_c;
    logic [CNT_W-1:0]    lit_count;
    logic [1:0]          wt;
    logic [13:0]         payload;

    assign wt      = word_type(mem_data);
    assign payload = word_payload(mem_data);

    lit_accum #(.MAX_CHUNKS(MAX_CHUNKS)) u_lit (
        .clk      (clk),
        .rst      (rst),
        .clear    (lit_clear),
        .load     (lit_load),
        .set_ovl  (lit_set_ovl),
        .payload  (payload),
        .value_c  (lit_value_c),
        .count    (lit_count),
        .overlong (err_overlong)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_WAIT;
            S_WAIT:   state_d = S_DECODE;
            S_DECODE: begin
                if (wt == WT_IGN || wt == WT_CPU) begin
                    state_d = S_EMIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EMIT:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        exec_d      = exec_q;
        kind_d      = kind_q;
        instr_d     = instr_q;
        value_d     = value_q;
        pcp_d       = pcp_q;
        err_rsv_d   = err_rsv_q;
        lit_clear   = 1'b0;
        lit_load    = 1'b0;
        lit_set_ovl = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_addr_d = start_pcp;
                    exec_d     = exec;
                    err_rsv_d  = 1'b0;
                    lit_clear  = 1'b1;
                end
            end
            S_DECODE: begin
                case (wt)
                    WT_DNL: begin
                        lit_load   = 1'b1;
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                    WT_IGN: begin
                        lit_load = 1'b1;
                        kind_d   = exec_q ? K_PUSH : K_SKIP;
                        value_d  = exec_q ? lit_value_c : '0;
                        pcp_d    = mem_addr_q + ADDR_W'(1);
                    end
                    WT_CPU: begin
                        kind_d      = K_INSTR;
                        instr_d     = payload;
                        value_d     = '0;
                        pcp_d       = mem_addr_q + ADDR_W'(1);
                        // A pending literal cut short by an instruction is lost.
                        lit_set_ovl = (lit_count != '0);
                    end
                    default: begin
                        err_rsv_d  = 1'b1;
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                endcase
            end
            default: ;
        endcase
        out_valid_d = (state_d == S_EMIT);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            exec_q      <= 1'b0;
            out_valid_q <= 1'b0;
            kind_q      <= K_PUSH;
            instr_q     <= '0;
            value_q     <= '0;
            pcp_q       <= '0;
            busy_q      <= 1'b0;
            err_rsv_q   <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            exec_q      <= exec_d;
            out_valid_q <= out_valid_d;
            kind_q      <= kind_d;
            instr_q     <= instr_d;
            value_q     <= value_d;
            pcp_q       <= pcp_d;
            busy_q      <= busy_d;
            err_rsv_q   <= err_rsv_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_kind  = kind_q;
    assign out_instr = instr_q;
    assign out_value = value_q;
    assign out_pcp   = pcp_q;
    assign busy      = busy_q;
    assign err_rsv   = err_rsv_q;

endmodule

// File: tb/tb_code_fetch.sv
// tb_code_fetch: directed test of code_fetch against a small BRAM model.
module tb_code_fetch;
    import cpu7_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [27:0] start_pcp;
    logic        exec;
    logic [27:0] mem_addr;
    logic [15:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [13:0] out_instr;
    logic [55:0] out_value;
    logic [27:0] out_pcp;
    logic        busy;
    logic        err_overlong;
    logic        err_rsv;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    // One-cycle registered-read BRAM, indexed by the low address byte.
    always @(posedge clk) mem_data <= mem[mem_addr[7:0]];

    code_fetch dut (
        .clk(clk), .rst(rst), .start(start), .start_pcp(start_pcp), .exec(exec),
        .mem_addr(mem_addr), .mem_data(mem_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_instr(out_instr),
        .out_value(out_value), .out_pcp(out_pcp), .busy(busy),
        .err_overlong(err_overlong), .err_rsv(err_rsv)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start (accepted at the next edge = end of cycle 0), then report
    // the cycle in which out_valid is first seen.
    task automatic run_item(input logic [27:0] pcp, input logic ex, output int c);
        start_pcp = pcp;
        exec      = ex;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (out_valid !== 1'b1 && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
        mem[8'h10] = 16'h8123;
        mem[8'h20] = 16'h0001; mem[8'h21] = 16'h0002; mem[8'h22] = 16'h4003;
        mem[8'h30] = 16'h7FFF;
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 16'h0001;
        mem[8'h44] = 16'h4001;
        mem[8'h50] = 16'hC000; mem[8'h51] = 16'h8001;
        mem[8'h60] = 16'h0005; mem[8'h61] = 16'h8007;
        mem[8'hFF] = 16'h8002;

        rst = 1'b1; start = 1'b0; start_pcp = '0; exec = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_kind", 64'(out_kind), 64'(K_PUSH));
        check("rst_value", 64'(out_value), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_pcp", 64'(out_pcp), 64'd0);
        check("rst_errs", 64'({err_overlong, err_rsv}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single CPU instruction.
        run_item(28'h10, 1'b1, cyc);
        check("instr_cyc", 64'(cyc), 64'd3);
        check("instr_kind", 64'(out_kind), 64'(K_INSTR));
        check("instr_val", 64'(out_instr), 64'h0123);
        check("instr_pcp", 64'(out_pcp), 64'h11);
        check("instr_busy", 64'(busy), 64'd1);

        // Three-chunk literal pushed.
        handshake();
        run_item(28'h20, 1'b1, cyc);
        check("lit3_cyc", 64'(cyc), 64'd7);
        check("lit3_kind", 64'(out_kind), 64'(K_PUSH));
        check("lit3_value", 64'(out_value), 64'h30008001);
        check("lit3_pcp", 64'(out_pcp), 64'h23);

        // One-chunk literal with bit 13 set.
        handshake();
        run_item(28'h30, 1'b1, cyc);
        check("ext_cyc", 64'(cyc), 64'd3);
`ifdef CODE_FETCH_SIGN_EXT_EN
        check("ext_value", 64'(out_value), 64'h00FF_FFFF_FFFF_FFFF);
`else
        check("ext_value", 64'(out_value), 64'h3FFF);
`endif

        // Five chunks: the fifth is dropped.
        handshake();
        run_item(28'h40, 1'b1, cyc);
        check("ovl_cyc", 64'(cyc), 64'd11);
        check("ovl_flag", 64'(err_overlong), 64'd1);
        check("ovl_value", 64'(out_value), 64'h0000_0400_1000_4001);
        check("ovl_pcp", 64'(out_pcp), 64'h45);

        // Reserved word then instruction; overlong cleared by the new start.
        handshake();
        run_item(28'h50, 1'b1, cyc);
        check("rsv_cyc", 64'(cyc), 64'd5);
        check("rsv_flag", 64'(err_rsv), 64'd1);
        check("rsv_ovl_clr", 64'(err_overlong), 64'd0);
        check("rsv_instr", 64'(out_instr), 64'h0001);
        check("rsv_pcp", 64'(out_pcp), 64'h52);

        // Literal chunk cut short by an instruction.
        handshake();
        run_item(28'h60, 1'b1, cyc);
        check("cut_kind", 64'(out_kind), 64'(K_INSTR));
        check("cut_instr", 64'(out_instr), 64'h0007);
        check("cut_ovl", 64'(err_overlong), 64'd1);
        check("cut_rsv_clr", 64'(err_rsv), 64'd0);
        check("cut_pcp", 64'(out_pcp), 64'h62);

        // Pointer wrap-around.
        handshake();
        run_item(28'hFFF_FFFF, 1'b1, cyc);
        check("wrap_instr", 64'(out_instr), 64'h0002);
        check("wrap_pcp", 64'(out_pcp), 64'h0);

        // Backpressure with a start pulse while emitting.
        handshake();
        run_item(28'h10, 1'b1, cyc);
        for (int k = 0; k < 5; k++) begin
            start     = (k == 2);
            start_pcp = 28'h20;
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_instr", 64'(out_instr), 64'h0123);
            check("stall_pcp", 64'(out_pcp), 64'h11);
            check("stall_addr", 64'(mem_addr), 64'h10);
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        check("hs_busy", 64'(busy), 64'd0);
        check("hs_valid", 64'(out_valid), 64'd0);
        check("hs_addr", 64'(mem_addr), 64'h10);
        @(posedge clk); #1;
        check("hs_idle", 64'(busy), 64'd0);

        // Literal consumed without execution.
        run_item(28'h20, 1'b0, cyc);
        check("skip_kind", 64'(out_kind), 64'(K_SKIP));
        check("skip_value", 64'(out_value), 64'd0);
        check("skip_pcp", 64'(out_pcp), 64'h23);
        handshake();

        // Reset in the middle of a literal, then a clean fetch.
        start_pcp = 28'h40; exec = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_addr", 64'(mem_addr), 64'd0);
        run_item(28'h20, 1'b1, cyc);
        check("post_cyc", 64'(cyc), 64'd7);
        check("post_value", 64'(out_value), 64'h30008001);
        check("post_ovl", 64'(err_overlong), 64'd0);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
